// File: rtl/acc_pkg.sv
// Shared types and helpers for the partial-sum accumulator: word widths, FSM states and
// the lane-slice helper used to pick one lane out of a packed multi-lane bus.
package acc_pkg;

  localparam int unsigned IW = 24;
  localparam int unsigned FW = 8;
  localparam int unsigned GW = 8;
  localparam int unsigned DW = IW + FW;
  localparam int unsigned AW = DW + GW;

  // Widest packed bus the slice helper accepts; narrower buses are zero-padded by the caller.
  localparam int unsigned MAX_LANES = 16;
  localparam int unsigned MAX_BUS   = MAX_LANES * DW;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StAcc  = 2'd1,
    StOut  = 2'd2
  } state_e;

  function automatic logic [DW-1:0] lane_slice(input logic [MAX_BUS-1:0] bus,
                                               input int unsigned k);
    return bus[k*DW +: DW];
  endfunction

endpackage

// File: rtl/psum_lane.sv
// One accumulator lane: AW-bit signed accumulator plus registered DW-bit output stage.
// Build with PSUM_SAT_EN defined to saturate the output instead of wrapping.
module psum_lane
  import acc_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          en,
  input  logic          load,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout
);

  logic [AW-1:0] acc_q;
  logic [AW-1:0] acc_sum;
  logic [DW-1:0] out_q;
  logic [DW-1:0] out_val;

  assign acc_sum = acc_q + {{GW{din[DW-1]}}, din};

`ifdef PSUM_SAT_EN
  // Guard bits plus the DW sign bit must all agree, otherwise the value is out of range.
  always_comb begin
    out_val = acc_sum[DW-1:0];
    if (acc_sum[AW-1:DW-1] != {(GW+1){acc_sum[AW-1]}}) begin
      out_val = acc_sum[AW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    end
  end
`else
  assign out_val = acc_sum[DW-1:0];
`endif

  // The output register loads on the final psum so data and out_vld appear together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      out_q <= '0;
    end else begin
      if (clear) begin
        acc_q <= '0;
      end else if (en) begin
        acc_q <= acc_sum;
      end
      if (load) begin
        out_q <= out_val;
      end
    end
  end

  assign dout = out_q;

endmodule

// File: rtl/psum_accum.sv
// Partial-sum accumulator: sums PE products over cin_num channels and hands the lanes
// downstream on a valid/ready port. PSUM_SAT_EN selects saturating output lanes.
module psum_accum
  import acc_pkg::*;
#(
  parameter int unsigned OUTPUT_NUM = 7,
  parameter int unsigned CW         = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [CW-1:0]          cin_num,
  input  logic [OUTPUT_NUM*DW-1:0] psum_i,
  input  logic                   psum_vld,
  output logic                   psum_rdy,
  output logic [OUTPUT_NUM*DW-1:0] out_data,
  output logic                   out_vld,
  input  logic                   out_rdy,
  output logic                   busy,
  output logic                   done
);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cin_q;
  logic          done_q;

  logic start_ok;
  logic acc_en;
  logic last;
  logic handshake;
  logic clear;

  logic [MAX_BUS-1:0] psum_pad;

  assign start_ok  = (state_q == StIdle) && start;
  assign acc_en    = (state_q == StAcc) && psum_vld;
  assign last      = acc_en && (cnt_q == cin_q - 1'b1);
  assign handshake = (state_q == StOut) && out_rdy;
  assign clear     = start_ok || handshake;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start)   state_d = StAcc;
      StAcc:   if (last)    state_d = StOut;
      StOut:   if (out_rdy) state_d = StIdle;
      default:              state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      cin_q   <= CW'(1);
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= handshake;
      if (start_ok) begin
        cnt_q <= '0;
        cin_q <= (cin_num == '0) ? CW'(1) : cin_num;
      end else if (acc_en) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign psum_pad = MAX_BUS'(psum_i);

  for (genvar k = 0; k < OUTPUT_NUM; k++) begin : g_lane
    psum_lane u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (clear),
      .en    (acc_en),
      .load  (last),
      .din   (lane_slice(psum_pad, k)),
      .dout  (out_data[k*DW +: DW])
    );
  end

  assign psum_rdy = (state_q == StAcc);
  assign out_vld  = (state_q == StOut);
  assign busy     = (state_q != StIdle);
  assign done     = done_q;

endmodule
